t01_blocktype_ctrl: RTL and testbench

Produces the 5-bit block-type code consumed by the 4x4 pattern generator, acting as the producer side of that interface. It selects each new piece from a free-running LFSR and tracks the active piece's rotation. Every rotation is checked against the board by an external collision checker through a request/verdict handshake before it is committed. It sits between the game FSM (spawn and rotate commands) and the pattern generator plus collision logic.

---
 rtl/t01_tetris_pkg.sv | 45 ++++
 rtl/t01_blocktype_ctrl_if.sv | 30 +++
 rtl/t01_piece_lfsr.sv | 36 +++
 rtl/t01_blocktype_ctrl.sv | 148 ++++++++++++++
 tb/tb_t01_blocktype_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t01_tetris_pkg.sv
// Shared types and helpers for the block-type controller: piece and state
// encodings, the (piece, rotation) -> pattern code map, and the LFSR piece pick.
package t01_tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_S = 3'd2,
        PIECE_Z = 3'd3,
        PIECE_J = 3'd4,
        PIECE_L = 3'd5,
        PIECE_T = 3'd6
    } piece_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    localparam logic [4:0]  BLOCK_NONE = 5'd31;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    // Two-orientation pieces only flip on rot[0]; J/L/T own three extra codes each.
    function automatic logic [4:0] block_code(input piece_t piece, input logic [1:0] rot);
        logic [4:0] code;
        code = BLOCK_NONE;
        case (piece)
            PIECE_I: code = rot[0] ? 5'd7 : 5'd0;
            PIECE_O: code = 5'd1;
            PIECE_S: code = rot[0] ? 5'd8 : 5'd2;
            PIECE_Z: code = rot[0] ? 5'd9 : 5'd3;
            PIECE_J: code = (rot == 2'd0) ? 5'd4 : (5'd9 + {3'd0, rot});
            PIECE_L: code = (rot == 2'd0) ? 5'd5 : (5'd12 + {3'd0, rot});
            PIECE_T: code = (rot == 2'd0) ? 5'd6 : (5'd15 + {3'd0, rot});
            default: code = BLOCK_NONE;
        endcase
        return code;
    endfunction

    function automatic piece_t pick_piece(input logic [2:0] low);
        return (low == 3'd7) ? PIECE_I : piece_t'(low);
    endfunction

endpackage

// File: rtl/t01_blocktype_ctrl_if.sv
// Command, verdict and block-code signals between the game side and the
// block-type controller; the controller uses the slave modport.
interface t01_blocktype_ctrl_if;

    logic       spawn_req;
    logic       rot_cw;
    logic       rot_ccw;
    logic       rot_ok_valid;
    logic       rot_ok;
    logic [4:0] current_block_type;
    logic [4:0] proposed_block_type;
    logic       rot_check_req;
    logic       rot_done;
    logic       rot_reject;
    logic [2:0] next_piece;
    logic       piece_valid;

    modport master (
        output spawn_req, rot_cw, rot_ccw, rot_ok_valid, rot_ok,
        input  current_block_type, proposed_block_type, rot_check_req,
               rot_done, rot_reject, next_piece, piece_valid
    );

    modport slave (
        input  spawn_req, rot_cw, rot_ccw, rot_ok_valid, rot_ok,
        output current_block_type, proposed_block_type, rot_check_req,
               rot_done, rot_reject, next_piece, piece_valid
    );

endinterface

// File: rtl/t01_piece_lfsr.sv
// Free-running 16-bit Galois LFSR; its low bits are folded into a 0..6 piece index.
module t01_piece_lfsr
    import t01_tetris_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       n_rst,
    output logic [2:0] piece
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Right-shifting Galois step; the bit shifted out selects the tap mask.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_MASK;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign piece = pick_piece(lfsr_q[2:0]);

endmodule

// File: rtl/t01_blocktype_ctrl.sv
// Block-type producer: spawns pieces from the LFSR preview, proposes rotations
// and commits them only after the collision checker's verdict or a timeout reject.
module t01_blocktype_ctrl
    import t01_tetris_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned CHECK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 n_rst,
    t01_blocktype_ctrl_if.slave  bus
);

    localparam logic [3:0] TIMEOUT_LAST = 4'(CHECK_TIMEOUT - 1);

    logic [2:0] lfsr_piece_s;
    logic       rot_one_s;
    logic [1:0] rot_tgt_s;

    state_t     state_q,     state_d;
    piece_t     piece_q,     piece_d;
    piece_t     next_q,      next_d;
    logic [1:0] rot_q,       rot_d;
    logic [1:0] prop_rot_q,  prop_rot_d;
    logic [4:0] cur_q,       cur_d;
    logic [4:0] prop_q,      prop_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       req_q,       req_d;
    logic       done_q,      done_d;
    logic       rej_q,       rej_d;
    logic       valid_q,     valid_d;

    t01_piece_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .n_rst (n_rst),
        .piece (lfsr_piece_s)
    );

    assign rot_one_s = bus.rot_cw ^ bus.rot_ccw;
    assign rot_tgt_s = bus.rot_cw ? (rot_q + 2'd1) : (rot_q - 2'd1);

    // Next-state and output logic; a spawn overrides every other event.
    always_comb begin
        state_d    = state_q;
        piece_d    = piece_q;
        next_d     = next_q;
        rot_d      = rot_q;
        prop_rot_d = prop_rot_q;
        cur_d      = cur_q;
        prop_d     = prop_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        rej_d      = 1'b0;

        if (bus.spawn_req) begin
            piece_d = next_q;
            rot_d   = 2'd0;
            cur_d   = block_code(next_q, 2'd0);
            next_d  = piece_t'(lfsr_piece_s);
            cnt_d   = 4'd0;
            state_d = ST_ACTIVE;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (rot_one_s && (piece_q != PIECE_O)) begin
                        prop_d     = block_code(piece_q, rot_tgt_s);
                        prop_rot_d = rot_tgt_s;
                        cnt_d      = 4'd0;
                        state_d    = ST_CHECK;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_CHECK: begin
                    // A verdict landing on the timeout cycle takes precedence.
                    if (bus.rot_ok_valid) begin
                        if (bus.rot_ok) begin
                            cur_d  = prop_q;
                            rot_d  = prop_rot_q;
                            done_d = 1'b1;
                        end else begin
                            rej_d = 1'b1;
                        end
                        cnt_d   = 4'd0;
                        state_d = ST_ACTIVE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        rej_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = ST_ACTIVE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_EMPTY: begin
                    state_d = ST_EMPTY;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        req_d   = (state_d == ST_CHECK);
        valid_d = (state_d != ST_EMPTY);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_EMPTY;
            piece_q    <= PIECE_I;
            next_q     <= pick_piece(LFSR_SEED[2:0]);
            rot_q      <= 2'd0;
            prop_rot_q <= 2'd0;
            cur_q      <= BLOCK_NONE;
            prop_q     <= BLOCK_NONE;
            cnt_q      <= 4'd0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            rej_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            piece_q    <= piece_d;
            next_q     <= next_d;
            rot_q      <= rot_d;
            prop_rot_q <= prop_rot_d;
            cur_q      <= cur_d;
            prop_q     <= prop_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            done_q     <= done_d;
            rej_q      <= rej_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.current_block_type  = cur_q;
    assign bus.proposed_block_type = prop_q;
    assign bus.rot_check_req       = req_q;
    assign bus.rot_done            = done_q;
    assign bus.rot_reject          = rej_q;
    assign bus.next_piece          = next_q;
    assign bus.piece_valid         = valid_q;

endmodule

// File: tb/tb_t01_blocktype_ctrl.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs and every
// done/reject event; a negedge monitor pops and compares them against the DUT.
module tb_t01_blocktype_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          TMO  = 15;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    t01_blocktype_ctrl_if bus_if ();

    t01_blocktype_ctrl #(
        .LFSR_SEED     (SEED),
        .CHECK_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] cur;
        logic [4:0] prop;
        logic       req;
        logic       done;
        logic       rej;
        logic [2:0] nxt;
        logic       valid;
    } snap_t;

    typedef struct packed {
        logic       is_done;
        logic [4:0] cur;
    } ev_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];
    snap_t mon_exp, mon_act;
    ev_t   mon_ev;

    int checks = 0;
    int errors = 0;

    int tab [7][4] = '{'{0, 7, 0, 7}, '{1, 1, 1, 1}, '{2, 8, 2, 8}, '{3, 9, 3, 9},
                       '{4, 10, 11, 12}, '{5, 13, 14, 15}, '{6, 16, 17, 18}};
    int t_seq [4]  = '{16, 17, 18, 6};

    bit          m_active, m_chk, m_done, m_rej;
    int          m_piece, m_rot, m_cur, m_prop, m_prop_rot, m_next, m_wait;
    logic [15:0] m_lfsr;

    function automatic int pick(input logic [15:0] x);
        int v;
        v = int'(x % 16'd8);
        return (v == 7) ? 0 : v;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        return (x % 16'd2 == 16'd1) ? ((x / 16'd2) ^ 16'hB400) : (x / 16'd2);
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_chk = 1'b0; m_done = 1'b0; m_rej = 1'b0;
        m_piece = 0; m_rot = 0; m_cur = 31; m_prop = 31; m_prop_rot = 0;
        m_next = pick(SEED); m_wait = 0; m_lfsr = SEED;
    endtask

    task automatic model_step(input bit sp, input bit cw, input bit ccw, input bit v, input bit ok);
        logic [15:0] old;
        int r;
        old = m_lfsr;
        m_lfsr = lfsr_adv(m_lfsr);
        m_done = 1'b0;
        m_rej  = 1'b0;
        if (sp) begin
            m_piece = m_next; m_rot = 0; m_cur = tab[m_next][0];
            m_next = pick(old); m_active = 1'b1; m_chk = 1'b0; m_wait = 0;
        end else if (m_chk) begin
            if (v) begin
                if (ok) begin
                    m_cur = m_prop; m_rot = m_prop_rot; m_done = 1'b1;
                end else begin
                    m_rej = 1'b1;
                end
                m_chk = 1'b0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_rej = 1'b1; m_chk = 1'b0; m_wait = 0;
                end
            end
        end else if (m_active && (cw != ccw) && m_piece != 1) begin
            r = cw ? (m_rot + 1) % 4 : (m_rot + 3) % 4;
            m_prop = tab[m_piece][r]; m_prop_rot = r; m_chk = 1'b1; m_wait = 0;
        end
    endtask

    task automatic push_expect();
        snap_t s;
        ev_t   e;
        s.cur = 5'(m_cur); s.prop = 5'(m_prop); s.req = m_chk; s.done = m_done;
        s.rej = m_rej; s.nxt = 3'(m_next); s.valid = m_active;
        snap_q.push_back(s);
        if (m_done || m_rej) begin
            e.is_done = m_done; e.cur = 5'(m_cur);
            ev_q.push_back(e);
        end
    endtask

    task automatic cyc(input bit sp, input bit cw, input bit ccw, input bit v, input bit ok);
        #1;
        bus_if.spawn_req = sp; bus_if.rot_cw = cw; bus_if.rot_ccw = ccw;
        bus_if.rot_ok_valid = v; bus_if.rot_ok = ok;
        @(posedge clk);
        if (!n_rst) model_reset();
        else model_step(sp, cw, ccw, v, ok);
        push_expect();
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic spawn_until(input int target);
        int n;
        n = 0;
        do begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (m_piece != target && n < 300);
        settle();
        chk("spawn_target_code", int'(bus_if.current_block_type), tab[target][0]);
    endtask

    // Monitor: compare every cycle's outputs and each done/reject event.
    always @(negedge clk) begin
        if (snap_q.size() > 0) begin
            mon_exp = snap_q.pop_front();
            mon_act.cur   = bus_if.current_block_type;
            mon_act.prop  = bus_if.proposed_block_type;
            mon_act.req   = bus_if.rot_check_req;
            mon_act.done  = bus_if.rot_done;
            mon_act.rej   = bus_if.rot_reject;
            mon_act.nxt   = bus_if.next_piece;
            mon_act.valid = bus_if.piece_valid;
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs actual=%h expected=%h at %0t", mon_act, mon_exp, $time);
            end
        end
        if (bus_if.rot_done || bus_if.rot_reject) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected done=%0b reject=%0b expected none at %0t",
                         bus_if.rot_done, bus_if.rot_reject, $time);
            end else begin
                mon_ev = ev_q.pop_front();
                if ({bus_if.rot_done, bus_if.rot_reject, bus_if.current_block_type} !==
                    {mon_ev.is_done, ~mon_ev.is_done, mon_ev.cur}) begin
                    errors++;
                    $display("FAIL pulse_event actual=%b/%b/%0d expected=%b/%b/%0d at %0t",
                             bus_if.rot_done, bus_if.rot_reject, bus_if.current_block_type,
                             mon_ev.is_done, ~mon_ev.is_done, mon_ev.cur, $time);
                end
            end
        end
    end

    initial begin
        int exp_code;
        bus_if.spawn_req = 1'b0; bus_if.rot_cw = 1'b0; bus_if.rot_ccw = 1'b0;
        bus_if.rot_ok_valid = 1'b0; bus_if.rot_ok = 1'b0;
        model_reset();

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("reset_cur", int'(bus_if.current_block_type), 31);
        chk("reset_prop", int'(bus_if.proposed_block_type), 31);
        chk("reset_valid", int'(bus_if.piece_valid), 0);
        chk("reset_next", int'(bus_if.next_piece), 1);
        chk("reset_pulses", int'({bus_if.rot_done, bus_if.rot_reject, bus_if.rot_check_req}), 0);
        n_rst = 1'b1;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("first_spawn_cur", int'(bus_if.current_block_type), 1);
        chk("first_spawn_valid", int'(bus_if.piece_valid), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("o_rot_no_req", int'(bus_if.rot_check_req), 0);
        chk("o_rot_cur", int'(bus_if.current_block_type), 1);

        spawn_until(6);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            settle();
            chk("t_cw_cur", int'(bus_if.current_block_type), t_seq[k]);
            chk("t_cw_done", int'(bus_if.rot_done), 1);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t_ccw_prop", int'(bus_if.proposed_block_type), 18);
        chk("t_ccw_req", int'(bus_if.rot_check_req), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        spawn_until(4);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("j_reject_pulse", int'(bus_if.rot_reject), 1);
        chk("j_reject_cur", int'(bus_if.current_block_type), 4);
        chk("j_reject_prop", int'(bus_if.proposed_block_type), 10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("timeout_req_rise", int'(bus_if.rot_check_req), 1);
        repeat (TMO - 1) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("timeout_not_early", int'(bus_if.rot_reject), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("timeout_reject", int'(bus_if.rot_reject), 1);
        chk("timeout_req_fall", int'(bus_if.rot_check_req), 0);

        spawn_until(0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk("i_wrap_ccw", int'(bus_if.current_block_type), 7);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk("i_wrap_back", int'(bus_if.current_block_type), 0);

        spawn_until(6);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_code = tab[m_next][0];
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk("abort_cur", int'(bus_if.current_block_type), exp_code);
        chk("abort_req", int'(bus_if.rot_check_req), 0);
        chk("abort_pulses", int'({bus_if.rot_done, bus_if.rot_reject}), 0);
        chk("abort_valid", int'(bus_if.piece_valid), 1);

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        chk("async_rst_cur", int'(bus_if.current_block_type), 31);
        chk("async_rst_prop", int'(bus_if.proposed_block_type), 31);
        chk("async_rst_req", int'(bus_if.rot_check_req), 0);
        chk("async_rst_valid", int'(bus_if.piece_valid), 0);
        chk("async_rst_next", int'(bus_if.next_piece), 1);
        chk("async_rst_pulses", int'({bus_if.rot_done, bus_if.rot_reject}), 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        n_rst = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
                $urandom_range(0, 1) == 1);
        end

        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", snap_q.size() + ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
